// File: rtl/uart_tx_sched_if.sv
// Producer/transmitter bundle for uart_tx_sched: two valid/ready byte ports in,
// paced UART write strobe and status out.
interface uart_tx_sched_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             req0_valid_i;
  logic [7:0]       req0_data_i;
  logic             req0_ready_o;
  logic             req1_valid_i;
  logic [7:0]       req1_data_i;
  logic             req1_ready_o;
  logic             uart_wr_o;
  logic [7:0]       uart_data_o;
  logic [CNT_W-1:0] fifo_count_o;
  logic             idle_o;

  modport master (
    output req0_valid_i, req0_data_i, req1_valid_i, req1_data_i,
    input  req0_ready_o, req1_ready_o, uart_wr_o, uart_data_o, fifo_count_o, idle_o
  );

  modport slave (
    input  req0_valid_i, req0_data_i, req1_valid_i, req1_data_i,
    output req0_ready_o, req1_ready_o, uart_wr_o, uart_data_o, fifo_count_o, idle_o
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin two-port byte scheduler feeding a busy-less UART transmitter through a FIFO.
// Strobe 2 cycles after accept when idle, BYTE_GAP cycles apart; both readies low while full.
module uart_tx_sched #(
  parameter int FIFO_DEPTH = 8,
  parameter int BYTE_GAP   = 1000,
  parameter int GAP_W      = 11
) (
  input  logic          sys_clk_i,
  input  logic          sys_rstn_i,
  uart_tx_sched_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(BYTE_GAP - 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             rr_q, rr_d;
  logic             wr_q, wr_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic       full;
  logic       gnt0, gnt1;
  logic       push, pop;
  logic [7:0] push_dat;

  // rr_q=0 favours port 0; the loser of a contested cycle wins the next one
  always_comb begin
    full     = (count_q == CNT_FULL);
    gnt0     = bus.req0_valid_i & ~full & (~bus.req1_valid_i | ~rr_q);
    gnt1     = bus.req1_valid_i & ~full & (~bus.req0_valid_i |  rr_q);
    push     = gnt0 | gnt1;
    push_dat = gnt1 ? bus.req1_data_i : bus.req0_data_i;
    rr_d     = push ? gnt0 : rr_q;
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        pop     = 1'b1;
        gap_d   = GAP_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (gap_q != '0)         gap_d   = gap_q - 1'b1;
        else if (count_q != '0)  state_d = S_ISSUE;
        else                     state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ISSUE) data_d = mem_q[rd_ptr_q];
    wr_d = (state_d == S_ISSUE);
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rr_q     <= 1'b0;
      wr_q     <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rr_q     <= rr_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
    end
  end

  // Storage is not reset: count and pointers alone define what is valid
  always_ff @(posedge sys_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign bus.req0_ready_o = gnt0;
  assign bus.req1_ready_o = gnt1;
  assign bus.uart_wr_o    = wr_q;
  assign bus.uart_data_o  = data_q;
  assign bus.fifo_count_o = count_q;
  assign bus.idle_o       = (state_q == S_IDLE) && (count_q == '0);
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queue-based reference schedule (strobe = max(accept+2, prev+BYTE_GAP))
// with a scoreboard monitor that checks every strobe's byte and cycle.
module tb_uart_tx_sched;
  localparam int DEPTH = 8;
  localparam int GAP   = 40;
  localparam int GAP_W = 11;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_sched #(
    .FIFO_DEPTH(DEPTH),
    .BYTE_GAP  (GAP),
    .GAP_W     (GAP_W)
  ) dut (
    .sys_clk_i (clk),
    .sys_rstn_i(rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic [7:0] d;
    longint     t;
  } exp_t;

  exp_t        scb_q[$];
  longint      model_t[$];
  logic [7:0]  src0[$];
  logic [7:0]  src1[$];
  logic [7:0]  tx_log[$];
  longint      cyc = 0;
  longint      last_iss;
  bit          rr_m;
  int          mode;
  int          acc_total;
  int          total = 0;
  int          bad   = 0;
  logic        sv_r0;
  logic        sv_idle;
  logic [CW-1:0] sv_cnt;
  logic [7:0]  last_tx;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Strobe monitor: pops the expected byte/cycle whenever the DUT writes.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_tx = 8'h00;
    end else begin
      if (scb_q.size() > 0) begin
        chk("strobe_not_late", longint'(scb_q[0].t >= cyc), 1);
        if (scb_q[0].t < cyc) void'(scb_q.pop_front());
      end
      if (bus.uart_wr_o) begin
        chk("strobe_expected", longint'(scb_q.size() > 0), 1);
        if (scb_q.size() > 0) begin
          mon_e = scb_q.pop_front();
          chk("tx_data", longint'(bus.uart_data_o), longint'(mon_e.d));
          chk("tx_cycle", cyc, mon_e.t);
          last_tx = mon_e.d;
        end
        tx_log.push_back(bus.uart_data_o);
      end else begin
        chk("data_hold", longint'(bus.uart_data_o), longint'(last_tx));
      end
    end
  end

  task automatic drive(input bit a0, input bit a1);
    bit h0, h1, v0, v1, iss;
    int cnt;
    h0  = bus.req0_valid_i && !a0;
    h1  = bus.req1_valid_i && !a1;
    cnt = 0;
    iss = 1'b0;
    foreach (model_t[i]) begin
      if (model_t[i] >= cyc) cnt++;
      if (model_t[i] == cyc) iss = 1'b1;
    end
    case (mode)
      1: begin
        v0 = (src0.size() > 0) && (h0 || $urandom_range(0, 2) == 0);
        v1 = (src1.size() > 0) && (h1 || $urandom_range(0, 2) == 0);
      end
      2: begin
        v0 = (src0.size() > 0) && (h0 || cnt < 3 || iss);
        v1 = (src1.size() > 0) && (h1 || cnt < 3 || iss);
      end
      default: begin
        v0 = (src0.size() > 0);
        v1 = (src1.size() > 0);
      end
    endcase
    bus.req0_valid_i = v0;
    bus.req0_data_i  = v0 ? src0[0] : 8'h00;
    bus.req1_valid_i = v1;
    bus.req1_data_i  = v1 ? src1[0] : 8'h00;
  endtask

  // One clock: check readies/count/idle against the model, record acceptances, advance stimulus.
  task automatic step();
    bit v0, v1, er0, er1;
    longint t;
    @(negedge clk);
    while (model_t.size() > 0 && model_t[0] < cyc) void'(model_t.pop_front());
    v0  = bus.req0_valid_i;
    v1  = bus.req1_valid_i;
    er0 = (model_t.size() < DEPTH) && v0 && (!v1 || !rr_m);
    er1 = (model_t.size() < DEPTH) && v1 && (!v0 ||  rr_m);
    sv_r0   = bus.req0_ready_o;
    sv_cnt  = bus.fifo_count_o;
    sv_idle = bus.idle_o;
    chk("ready0", longint'(bus.req0_ready_o), longint'(er0));
    chk("ready1", longint'(bus.req1_ready_o), longint'(er1));
    chk("ready_onehot", longint'(bus.req0_ready_o & bus.req1_ready_o), 0);
    chk("count", longint'(bus.fifo_count_o), longint'(model_t.size()));
    chk("idle", longint'(bus.idle_o), longint'(model_t.size() == 0 && cyc >= last_iss + GAP));
    if (er0 || er1) begin
      t = (cyc + 2 > last_iss + GAP) ? cyc + 2 : last_iss + GAP;
      last_iss = t;
      model_t.push_back(t);
      scb_q.push_back('{d: (er0 ? bus.req0_data_i : bus.req1_data_i), t: t});
      rr_m = er0;
      acc_total++;
    end
    @(posedge clk);
    #1;
    if (er0) void'(src0.pop_front());
    if (er1) void'(src1.pop_front());
    drive(er0, er1);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bus.req0_valid_i = 1'b0;
    bus.req0_data_i  = 8'h00;
    bus.req1_valid_i = 1'b0;
    bus.req1_data_i  = 8'h00;
    src0.delete();
    src1.delete();
    scb_q.delete();
    model_t.delete();
    last_iss  = -1000000;
    rr_m      = 1'b0;
    mode      = 0;
    acc_total = 0;
    #1;
    chk("rst_count", longint'(bus.fifo_count_o), 0);
    chk("rst_wr", longint'(bus.uart_wr_o), 0);
    chk("rst_data", longint'(bus.uart_data_o), 0);
    chk("rst_idle", longint'(bus.idle_o), 1);
    repeat (n) begin
      @(negedge clk);
      chk("rst_ready0", longint'(bus.req0_ready_o), 0);
      chk("rst_ready1", longint'(bus.req1_ready_o), 0);
      chk("rst_hold_wr", longint'(bus.uart_wr_o), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tx_log.delete();
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((src0.size() > 0 || src1.size() > 0 || scb_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", longint'(n < budget), 1);
    repeat (GAP + 1) step();
    chk("final_idle", longint'(sv_idle), 1);
    chk("final_count", longint'(sv_cnt), 0);
  endtask

  logic [7:0] rr_exp [8] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};
  logic [7:0] pace_exp [3] = '{8'h41, 8'h42, 8'h43};

  initial begin
    int n;
    last_iss = -1000000;
    mode = 0;
    acc_total = 0;
    rr_m = 1'b0;
    bus.req0_valid_i = 1'b0;
    bus.req0_data_i  = 8'h00;
    bus.req1_valid_i = 1'b0;
    bus.req1_data_i  = 8'h00;
    @(posedge clk);
    #1;
    do_reset(3);

    // single byte: strobe two cycles after accept
    src0.push_back(8'h41);
    drive(1'b0, 1'b0);
    run_idle(4 * GAP);
    chk("single_n", longint'(tx_log.size()), 1);
    chk("single_data", longint'(tx_log.size() > 0 ? tx_log[0] : 8'h00), 32'h41);

    // pacing of three back-to-back bytes
    tx_log.delete();
    foreach (pace_exp[i]) src0.push_back(pace_exp[i]);
    drive(1'b0, 1'b0);
    run_idle(6 * GAP);
    chk("pace_n", longint'(tx_log.size()), 3);
    foreach (pace_exp[i])
      chk("pace_order", longint'(i < tx_log.size() ? tx_log[i] : 8'h00), longint'(pace_exp[i]));

    // round-robin with both ports continuously valid
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      src0.push_back(8'hA0 + 8'(i));
      src1.push_back(8'hB0 + 8'(i));
    end
    drive(1'b0, 1'b0);
    run_idle(12 * GAP);
    chk("rr_n", longint'(tx_log.size()), 8);
    foreach (rr_exp[i])
      chk("rr_order", longint'(i < tx_log.size() ? tx_log[i] : 8'h00), longint'(rr_exp[i]));

    // fill to full: 9 accepts, then ready drops with count at depth
    do_reset(2);
    for (int i = 0; i < 10; i++) src0.push_back(8'h80 + 8'(i));
    drive(1'b0, 1'b0);
    n = 0;
    while (acc_total < 9 && n < 50) begin
      step();
      n++;
    end
    chk("full_reached", longint'(acc_total), 9);
    step();
    chk("full_count", longint'(sv_cnt), DEPTH);
    chk("full_ready0", longint'(sv_r0), 0);
    run_idle(14 * GAP);
    chk("full_n", longint'(tx_log.size()), 10);

    // push coincident with pop at count 3, 12 bytes through a pointer wrap
    do_reset(2);
    mode = 2;
    for (int i = 0; i < 12; i++) src0.push_back(8'hC0 + 8'(i));
    drive(1'b0, 1'b0);
    run_idle(16 * GAP);
    chk("wrap_n", longint'(tx_log.size()), 12);
    for (int i = 0; i < 12; i++)
      chk("wrap_order", longint'(i < tx_log.size() ? tx_log[i] : 8'h00), 32'hC0 + i);

    // reset during WAIT with 5 bytes buffered
    do_reset(2);
    for (int i = 0; i < 6; i++) src0.push_back(8'h60 + 8'(i));
    drive(1'b0, 1'b0);
    n = 0;
    while (tx_log.size() == 0 && n < 20) begin
      step();
      n++;
    end
    repeat (10) step();
    chk("midop_count", longint'(sv_cnt), 5);
    do_reset(3);
    run_idle(2 * GAP);
    chk("midop_no_stale", longint'(tx_log.size()), 0);
    src0.push_back(8'h7E);
    drive(1'b0, 1'b0);
    run_idle(4 * GAP);
    chk("midop_after_n", longint'(tx_log.size()), 1);
    chk("midop_after_data", longint'(tx_log.size() > 0 ? tx_log[0] : 8'h00), 32'h7E);

    // random valids on both ports
    do_reset(2);
    mode = 1;
    for (int i = 0; i < 20; i++) begin
      src0.push_back(8'($urandom_range(0, 255)));
      src1.push_back(8'($urandom_range(0, 255)));
    end
    drive(1'b0, 1'b0);
    run_idle(50 * GAP);
    chk("rand_n", longint'(tx_log.size()), 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Schedules bytes into the existing single-byte UART transmitter, which exposes only a write strobe and data byte and has no busy output.
- Arbitrates round-robin between two byte producers (port 0: CPU MMIO store path; port 1: debug/trace dumper).
- Buffers accepted bytes in a small FIFO.
- Paces write strobes with a fixed byte-time gap so no byte is dropped by the busy transmitter.

Parameters:
- FIFO_DEPTH, 8: FIFO entries; power of two, at least 2.
- BYTE_GAP, 1000: clock cycles between consecutive uart_wr_o pulses. Must be at least 2 and at least one 11-bit frame time; 10 MHz / 115200 gives about 955.
- GAP_W, 11: width of the gap counter; must hold BYTE_GAP-2.

Ports:
- sys_clk_i  input  1  system clock
- sys_rstn_i  input  1  reset, asynchronous, active-low
- req0_valid_i  input  1  port 0 byte available
- req0_data_i  input  8  port 0 byte
- req0_ready_o  output  1  port 0 byte accepted this cycle when valid
- req1_valid_i  input  1  port 1 byte available
- req1_data_i  input  8  port 1 byte
- req1_ready_o  output  1  port 1 byte accepted this cycle when valid
- uart_wr_o  output  1  one-cycle write strobe to transmitter
- uart_data_o  output  8  byte to transmitter
- fifo_count_o  output  log2(FIFO_DEPTH)+1  current FIFO occupancy
- idle_o  output  1  FIFO empty and sender idle

Behaviour:
- Reset (async, sys_rstn_i low):
  - FIFO emptied; fifo_count_o=0.
  - Round-robin pointer favours port 0.
  - FSM to IDLE; gap counter 0.
  - uart_wr_o=0, uart_data_o=8'h00, idle_o=1.
  - Reset mid-frame drops all buffered bytes. The transmitter shares this reset, so no partial frame survives.
- Producer handshake:
  - Transfer on valid & ready at the rising edge.
  - Producer holds valid and data stable until accepted.
- Arbitration (combinational ready):
  - FIFO full: both readies 0. No same-cycle pass-through on a pop.
  - Not full, only one valid: that port is ready.
  - Not full, both valid: the port favoured by the pointer is ready; the other is 0.
  - At most one push per cycle.
  - After a push, the pointer favours the port that was not just granted. Otherwise it is unchanged.
  - Ready with valid low: 0.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a count register.
  - Push and pop in the same cycle leaves the count unchanged and is legal at any occupancy, including full, where no push can occur anyway.
  - Order is preserved across both ports in acceptance order.
- Sender FSM states: IDLE, ISSUE, WAIT.
  - IDLE: count>0 -> ISSUE; otherwise stay.
  - ISSUE (one cycle):
    - uart_wr_o=1; uart_data_o holds the FIFO head, registered on entry.
    - Pop the head; load gap counter with BYTE_GAP-2; -> WAIT.
  - WAIT:
    - Counter nonzero: decrement and stay.
    - Counter 0 and count>0: -> ISSUE.
    - Counter 0 and count=0: -> IDLE.
- Outputs:
  - uart_wr_o is registered and high only in ISSUE.
  - uart_data_o is updated only on entry to ISSUE and holds its value otherwise.
  - idle_o = (state==IDLE) & (count==0).
- Timing:
  - A byte accepted at edge t into an empty, idle block gives count=1 after t. The FSM is in IDLE during the cycle after t and enters ISSUE one cycle later, so uart_wr_o rises two cycles after acceptance.
  - Back-to-back uart_wr_o pulses are exactly BYTE_GAP cycles apart.
  - A byte arriving during WAIT is issued at the next gap boundary and not earlier.
- Widths: count saturates naturally at FIFO_DEPTH. Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.

Test Plan:
- Reset: hold sys_rstn_i low -> uart_wr_o=0, uart_data_o=00, fifo_count_o=0, idle_o=1, both readies 0 with valids low. Deassert, then push 8'h41 on port 0 at edge t -> uart_wr_o high only in the cycle two cycles after t, uart_data_o=41, idle_o=1 once WAIT completes.
- Pacing: push 41,42,43 consecutively on port 0 -> three uart_wr_o pulses exactly BYTE_GAP cycles apart, data 41,42,43.
- Round-robin: both valid continuously, port 0 stream A0..A3, port 1 stream B0..B3 -> acceptance and transmit order A0,B0,A1,B1,A2,B2,A3,B3. Never both readies high.
- Full: with BYTE_GAP=1000, push 10 bytes on port 0 -> after 9 accepts (1 issued, 8 buffered), ready drops and fifo_count_o=8. Ready reasserts the cycle after the next ISSUE pop, and all 10 bytes emit in order.
- Simultaneous push/pop: FIFO at count 3, push coincident with ISSUE -> count stays 3, correct byte order through a pointer wrap (write 12 bytes total).
- Reset mid-operation: assert reset during WAIT with 5 bytes buffered -> immediate count=0, uart_wr_o=0. After release, no stale byte is ever emitted.
